// File: rtl/cnn_sdiv_24s_14s_10s_if.sv
// Operand/result bundle for the signed 24/14 -> 10 iterative divider.
// Ports: in_valid/in_ready/dividend/divisor (request), out_valid/out_ready/
//        quotient/remainder/div_zero/ovf (response); master drives requests.
interface cnn_sdiv_24s_14s_10s_if #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 14,
  parameter int QUOT_W     = 10
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [QUOT_W-1:0]     quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         div_zero;
  logic                         ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, ovf
  );
endinterface

// File: rtl/cnn_sdiv_24s_14s_10s.sv
// Signed restoring divider: 24b dividend / 14b divisor -> 10b quotient + 14b remainder.
// Latency 24 cycles accept->out_valid; one result per 26 cycles max; in_ready=0 while busy,
// result held in DONE until out_ready. Optional macro CNN_SDIV_SAT_EN clamps the quotient
// and reports ovf; without it the quotient wraps and ovf is 0.
// Ports: ap_clk, ap_rst_n (async active-low), io (slave side of cnn_sdiv_24s_14s_10s_if).
module cnn_sdiv_24s_14s_10s #(
  parameter int DIVIDEND_W = 24,
  parameter int DIVISOR_W  = 14,
  parameter int QUOT_W     = 10
) (
  input logic                     ap_clk,
  input logic                     ap_rst_n,
  cnn_sdiv_24s_14s_10s_if.slave   io
);

  localparam int DW    = DIVIDEND_W;
  localparam int SW    = DIVISOR_W;
  localparam int QW    = QUOT_W;
  localparam int CNT_W = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     dvd_q, dvd_d;      // dividend bits shift out of MSB, quotient bits in at LSB
  logic [SW-1:0]     dsr_q, dsr_d;      // |divisor|
  logic [SW-1:0]     prem_q, prem_d;    // partial remainder, always < |divisor| between steps
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_dvd_q, neg_dvd_d;
  logic              neg_dsr_q, neg_dsr_d;
  logic              dz_q, dz_d;
  logic [QW-1:0]     quot_q, quot_d;
  logic [SW-1:0]     rem_q, rem_d;
  logic              dzo_q, dzo_d;
  logic              ovf_q, ovf_d;

  // One restoring step. The shifted value needs SW+1 bits; after a subtract
  // the result is below |divisor| <= 2^(SW-1), so SW bits hold it.
  logic [SW:0]       shifted;
  logic              ge;
  logic [SW-1:0]     diff;
  logic [SW-1:0]     prem_nx;
  logic [DW-1:0]     dvd_nx;
  logic [SW-1:0]     rem_fin;
  logic [QW-1:0]     q_nar;
  logic              q_ovf;
  logic              q_neg;

  assign shifted = {prem_q, dvd_q[DW-1]};
  assign ge      = shifted >= {1'b0, dsr_q};
  assign diff    = shifted[SW-1:0] - dsr_q;
  assign prem_nx = ge ? diff : shifted[SW-1:0];
  assign dvd_nx  = {dvd_q[DW-2:0], ge};
  assign q_neg   = neg_dvd_q ^ neg_dsr_q;
  assign rem_fin = neg_dvd_q ? -prem_nx : prem_nx;

`ifdef CNN_SDIV_SAT_EN
  localparam logic signed [DW:0] Q_MAX = (DW+1)'(2**(QW-1) - 1);
  localparam logic signed [DW:0] Q_MIN = ~Q_MAX;

  logic signed [DW:0] q_full;
  assign q_full = q_neg ? -$signed({1'b0, dvd_nx}) : $signed({1'b0, dvd_nx});

  always_comb begin
    q_nar = q_full[QW-1:0];
    q_ovf = 1'b0;
    if (q_full > Q_MAX) begin
      q_nar = Q_MAX[QW-1:0];
      q_ovf = 1'b1;
    end else if (q_full < Q_MIN) begin
      q_nar = Q_MIN[QW-1:0];
      q_ovf = 1'b1;
    end
  end
`else
  // Low bits of the negated magnitude equal the negation of its low bits,
  // so wrapping needs only the bottom QW bits.
  assign q_nar = q_neg ? -dvd_nx[QW-1:0] : dvd_nx[QW-1:0];
  assign q_ovf = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    neg_dvd_d = neg_dvd_q;
    neg_dsr_d = neg_dsr_q;
    dz_d      = dz_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dzo_d     = dzo_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          neg_dvd_d = io.dividend[DW-1];
          neg_dsr_d = io.divisor[SW-1];
          dvd_d     = io.dividend[DW-1] ? -io.dividend : io.dividend;
          dsr_d     = io.divisor[SW-1]  ? -io.divisor  : io.divisor;
          dz_d      = (io.divisor == '0);
          prem_d    = '0;
          cnt_d     = CNT_W'(DW - 1);
          state_d   = CALC;
        end
      end
      CALC: begin
        dvd_d  = dvd_nx;
        prem_d = prem_nx;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (dz_q) begin
            // Saturate toward the dividend's sign; remainder is meaningless, report 0.
            quot_d = neg_dvd_q ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
            rem_d  = '0;
            dzo_d  = 1'b1;
            ovf_d  = 1'b0;
          end else begin
            quot_d = q_nar;
            rem_d  = rem_fin;
            dzo_d  = 1'b0;
            ovf_d  = q_ovf;
          end
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      neg_dvd_q <= 1'b0;
      neg_dsr_q <= 1'b0;
      dz_q      <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dzo_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dsr_q <= neg_dsr_d;
      dz_q      <= dz_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dzo_q     <= dzo_d;
      ovf_q     <= ovf_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.quotient  = quot_q;
  assign io.remainder = rem_q;
  assign io.div_zero  = dzo_q;
  assign io.ovf       = ovf_q;

endmodule

// File: tb/tb_cnn_sdiv_24s_14s_10s.sv
// Directed bench for cnn_sdiv_24s_14s_10s: results, latency, hold/backpressure, reset abort.
// Expected values are hand-computed; saturating vs wrapping expectations follow CNN_SDIV_SAT_EN.
module tb_cnn_sdiv_24s_14s_10s;

  logic ap_clk;
  logic ap_rst_n;
  int   n_cmp;
  int   n_err;
  int   lat;

  cnn_sdiv_24s_14s_10s_if io ();

  cnn_sdiv_24s_14s_10s dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .io       (io)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before 400us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands on a falling edge, hold them through one rising edge,
  // then count rising edges until out_valid (bounded).
  task automatic issue(input string tag, input int a, input int b);
    @(negedge ap_clk);
    check({tag, ".in_ready_idle"}, io.in_ready, 1);
    io.dividend = 24'(a);
    io.divisor  = 14'(b);
    io.in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    io.in_valid = 1'b0;
    check({tag, ".in_ready_busy"}, io.in_ready, 0);
    lat = 0;
    while (io.out_valid !== 1'b1 && lat < 40) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 24);
  endtask

  task automatic expect_res(input string tag, input int q, input int r,
                            input int dz, input int ov);
    check({tag, ".quotient"},  io.quotient,  q);
    check({tag, ".remainder"}, io.remainder, r);
    check({tag, ".div_zero"},  io.div_zero,  dz);
    check({tag, ".ovf"},       io.ovf,       ov);
  endtask

  task automatic accept_out(input string tag);
    io.out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    io.out_ready = 1'b0;
    check({tag, ".out_valid_after"}, io.out_valid, 0);
    check({tag, ".in_ready_after"},  io.in_ready,  1);
  endtask

  task automatic div(input string tag, input int a, input int b, input int q,
                     input int r, input int dz, input int ov);
    issue(tag, a, b);
    expect_res(tag, q, r, dz, ov);
    accept_out(tag);
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.dividend  = '0;
    io.divisor   = '0;
    ap_rst_n     = 1'b0;
    #12;
    check("rst.in_ready",  io.in_ready,  1);
    check("rst.out_valid", io.out_valid, 0);
    expect_res("rst", 0, 0, 0, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    div("p_div_p",  1000,  7,  142,  6, 0, 0);
    div("n_div_p", -1000,  7, -142, -6, 0, 0);
    div("p_div_n",  1000, -7, -142,  6, 0, 0);
    div("small_n",    -7, 8191,   0, -7, 0, 0);
    div("edge_max",  5110, 10,  511,  0, 0, 0);
    div("edge_min", -5120, 10, -512,  0, 0, 0);

    // Full quotient +512: a 14-bit divisor cannot hold -16384, so use the
    // largest negative divisor with a dividend giving the same quotient.
`ifdef CNN_SDIV_SAT_EN
    div("q512",     -4194304, -8192,  511,     0, 0, 1);
    div("q1024",    -8388608, -8192,  511,     0, 0, 1);
    div("big_pos",   8388607,     1,  511,     0, 0, 1);
    div("big_neg",  -8388608,  8191, -512, -1024, 0, 1);
`else
    div("q512",     -4194304, -8192, -512,     0, 0, 0);
    div("q1024",    -8388608, -8192,    0,     0, 0, 0);
    div("big_pos",   8388607,     1,   -1,     0, 0, 0);
    div("big_neg",  -8388608,  8191,    0, -1024, 0, 0);
`endif

    div("dz_pos",   500, 0,  511, 0, 1, 0);
    div("dz_neg",  -500, 0, -512, 0, 1, 0);
    div("dz_zero",    0, 0,  511, 0, 1, 0);

    // Backpressure: result must hold while out_ready stays low; extra
    // requests during DONE must not be taken.
    issue("hold", 12345, 100);
    expect_res("hold", 123, 45, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      io.dividend = 24'(999);
      io.divisor  = 14'(3);
      io.in_valid = 1'b1;
      @(posedge ap_clk);
      #1;
      check("hold.in_ready",  io.in_ready,  0);
      check("hold.out_valid", io.out_valid, 1);
      check("hold.quotient",  io.quotient,  123);
      check("hold.remainder", io.remainder, 45);
    end
    io.in_valid = 1'b0;
    accept_out("hold");
    div("after_hold", 999, 3, 333, 0, 0, 0);

    // Reset in the middle of a division; registered results drop to 0 at once.
    @(negedge ap_clk);
    io.dividend = 24'(1000);
    io.divisor  = 14'(7);
    io.in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    io.in_valid = 1'b0;
    repeat (12) @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    check("abort.in_ready",  io.in_ready,  1);
    check("abort.out_valid", io.out_valid, 0);
    expect_res("abort", 0, 0, 0, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    div("post_rst", 77, 7, 11, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
